// File: rtl/dsm_pkg.sv
// Shared definitions for the delta-sigma chain: dither LFSR constants,
// the default output code type and the offset-binary helper.
package dsm_pkg;

  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11, as state bit positions
  localparam int LFSR_TAP_A = 15;
  localparam int LFSR_TAP_B = 13;
  localparam int LFSR_TAP_C = 12;
  localparam int LFSR_TAP_D = 10;

  localparam int MASH_BW_DEFAULT = 4;

  typedef logic signed [MASH_BW_DEFAULT-1:0] mash_t;

  // Two's complement to offset binary: flip the sign bit of a w-bit value
  function automatic logic [31:0] offset_binary(input logic [31:0] value, input int w);
    return value ^ (32'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/mash11_modulator_lfsr16.sv
// 16-bit Fibonacci LFSR used as a dither source; steps only when advance is high.
module lfsr16
  import dsm_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        aclk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;
  logic        newBit;

  if (SEED == 16'h0000) begin : g_bad_seed
    $error("lfsr16: SEED must be nonzero, an all-zero LFSR never leaves zero");
  end

  always_comb begin
    newBit  = state_q[LFSR_TAP_A] ^ state_q[LFSR_TAP_B] ^ state_q[LFSR_TAP_C] ^ state_q[LFSR_TAP_D];
    state_d = advance ? {state_q[14:0], newBit} : state_q;
  end

  always_ff @(posedge aclk) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/mash11_modulator.sv
// Second-order MASH 1-1 modulator: two cascaded first-order accumulators whose
// carries combine into a four-level code in {-1, 0, 1, 2}.
module mash11_modulator
  import dsm_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter int          MASH_BW   = MASH_BW_DEFAULT,
  parameter int          SIGNED_IN = 1,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic                      aclk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          tx_data,
  input  logic                      in_valid,
  input  logic                      dither_enable,
  output logic signed [MASH_BW-1:0] mash_data,
  output logic                      out_valid
);

  if (MASH_BW < 3) begin : g_bad_bw
    $error("mash11_modulator: MASH_BW must be at least 3 to hold the range -1..2");
  end
  if (WIDTH > 32 || WIDTH < 2) begin : g_bad_width
    $error("mash11_modulator: WIDTH must be in 2..32");
  end

  logic [WIDTH-1:0]          acc1_q, acc1_d;
  logic [WIDTH-1:0]          acc2_q, acc2_d;
  logic                      c2_q, c2_d;
  logic signed [MASH_BW-1:0] mash_q, mash_d;
  logic                      valid_q;

  logic [WIDTH-1:0]  x;
  logic [WIDTH:0]    sum1;
  logic [WIDTH:0]    sum2;
  logic              ditherBit;
  logic signed [2:0] codeSum;
  logic [15:0]       lfsrState;
  logic              unusedLfsrHi;

  // The LFSR steps on every accepted sample so the dither sequence does not
  // depend on when dither_enable was toggled.
  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .aclk   (aclk),
    .rst_n  (rst_n),
    .advance(in_valid),
    .state  (lfsrState)
  );

  assign unusedLfsrHi = ^lfsrState[15:1];

  always_comb begin
    x         = (SIGNED_IN != 0) ? WIDTH'(offset_binary(32'(tx_data), WIDTH)) : tx_data;
    ditherBit = dither_enable & lfsrState[0];
    sum1      = {1'b0, acc1_q} + {1'b0, x} + (WIDTH + 1)'(ditherBit);
    sum2      = {1'b0, acc2_q} + {1'b0, sum1[WIDTH-1:0]};
    acc1_d    = sum1[WIDTH-1:0];
    acc2_d    = sum2[WIDTH-1:0];
    c2_d      = sum2[WIDTH];
    // c1 + c2 - c2_prev fits in three signed bits; widen with sign extension
    codeSum   = 3'({2'b00, sum1[WIDTH]} + {2'b00, sum2[WIDTH]} - {2'b00, c2_q});
    mash_d    = MASH_BW'(codeSum);
  end

  always_ff @(posedge aclk) begin
    if (!rst_n) begin
      acc1_q  <= '0;
      acc2_q  <= '0;
      c2_q    <= 1'b0;
      mash_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        acc1_q <= acc1_d;
        acc2_q <= acc2_d;
        c2_q   <= c2_d;
        mash_q <= mash_d;
      end
    end
  end

  assign mash_data = mash_q;
  assign out_valid = valid_q;

endmodule
